// File: rtl/apb_mem_slave_if.sv
// APB bundle between a requester and apb_mem_slave.
// paddr width follows ADDR_W; data is always 32 bits.
interface apb_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB completer over a word array with wait states,
// decode errors and a side-band preload port.
module apb_mem_slave #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter bit                READ_ONLY   = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  apb_if.slave                           apb,
  input  logic                           load_en_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                    load_data_i,
  output logic                           busy_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] HI =
    LO + (ADDR_W+1)'(4 * DEPTH_WORDS);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic             err_q;
  logic [31:0]      wdata_q;
  logic [3:0]       strb_q;
  logic [31:0]      rdata_q;

  logic [ADDR_W:0]   addr_x;
  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx_c;
  logic              err_c;
  logic              done;
  logic              unused_off;

  // Range check is one bit wider than paddr so the top can't wrap.
  assign addr_x = {1'b0, apb.paddr};
  assign off    = apb.paddr - BASE_ADDR;
  assign idx_c  = off[IDX_W+1:2];
  assign err_c  = (apb.paddr[1:0] != 2'b00)
                | (addr_x < LO)
                | (addr_x >= HI)
                | (apb.pwrite & READ_ONLY);

  assign unused_off = ^{off[ADDR_W-1:IDX_W+2], off[1:0]};

  // A load in flight holds off completion.
  assign done = (state_q == ST_ACCESS)
              & apb.psel
              & (cnt_q == 4'd0)
              & ~load_en_i;

  assign apb.pready  = done;
  assign apb.pslverr = done & err_q;
  assign apb.prdata  = rdata_q;
  assign busy_o      = (state_q == ST_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (apb.psel && !apb.penable) begin
            state_q <= ST_ACCESS;
            cnt_q   <= 4'(WAIT_CYCLES);
            idx_q   <= idx_c;
            wr_q    <= apb.pwrite;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
            err_q   <= err_c;
            rdata_q <= err_c ? '0 : mem_q[idx_c];
          end
        end
        ST_ACCESS: begin
          if (!apb.psel) begin
            state_q <= ST_IDLE;
          end else if (cnt_q != 4'd0 || load_en_i) begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end
            rdata_q <= err_q ? '0 : mem_q[idx_q];
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (done && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
    if (load_en_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end
endmodule

// File: tb/tb_apb_mem_slave.sv
// Random APB traffic on four slave flavours, checked
// against a word-array model of the memory.
module tb_apb_mem_slave;
  localparam int ND  = 4;
  localparam int DEP = 64;
  localparam int IW  = 6;

  logic clk = 1'b0;
  logic rst_n;

  logic          psel    [ND];
  logic          penable [ND];
  logic          pwrite  [ND];
  logic [31:0]   paddr   [ND];
  logic [31:0]   pwdata  [ND];
  logic [3:0]    pstrb   [ND];
  logic [31:0]   rdata   [ND];
  logic          rdy     [ND];
  logic          serr    [ND];
  logic          busy    [ND];
  logic          ld_en   [ND];
  logic [IW-1:0] ld_addr [ND];
  logic [31:0]   ld_data [ND];

  logic [31:0] mm [ND][DEP];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_if #(.ADDR_W(32)) bus [ND] ();

  for (genvar k = 0; k < ND; k++) begin : g_bus
    assign bus[k].psel    = psel[k];
    assign bus[k].penable = penable[k];
    assign bus[k].pwrite  = pwrite[k];
    assign bus[k].paddr   = paddr[k];
    assign bus[k].pwdata  = pwdata[k];
    assign bus[k].pstrb   = pstrb[k];
    assign rdata[k]       = bus[k].prdata;
    assign rdy[k]         = bus[k].pready;
    assign serr[k]        = bus[k].pslverr;
  end

  apb_mem_slave #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH_WORDS(DEP),
    .WAIT_CYCLES(0), .READ_ONLY(1'b0)
  ) u_d0 (
    .clk(clk), .rst_n(rst_n), .apb(bus[0]),
    .load_en_i(ld_en[0]), .load_addr_i(ld_addr[0]),
    .load_data_i(ld_data[0]), .busy_o(busy[0])
  );

  apb_mem_slave #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH_WORDS(DEP),
    .WAIT_CYCLES(3), .READ_ONLY(1'b0)
  ) u_d1 (
    .clk(clk), .rst_n(rst_n), .apb(bus[1]),
    .load_en_i(ld_en[1]), .load_addr_i(ld_addr[1]),
    .load_data_i(ld_data[1]), .busy_o(busy[1])
  );

  apb_mem_slave #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH_WORDS(DEP),
    .WAIT_CYCLES(1), .READ_ONLY(1'b1)
  ) u_d2 (
    .clk(clk), .rst_n(rst_n), .apb(bus[2]),
    .load_en_i(ld_en[2]), .load_addr_i(ld_addr[2]),
    .load_data_i(ld_data[2]), .busy_o(busy[2])
  );

  apb_mem_slave #(
    .ADDR_W(32), .BASE_ADDR(32'h200), .DEPTH_WORDS(DEP),
    .WAIT_CYCLES(2), .READ_ONLY(1'b0)
  ) u_d3 (
    .clk(clk), .rst_n(rst_n), .apb(bus[3]),
    .load_en_i(ld_en[3]), .load_addr_i(ld_addr[3]),
    .load_data_i(ld_data[3]), .busy_o(busy[3])
  );

  function automatic int wait_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic longint base_of(input int d);
    return (d == 3) ? 64'h200 : 64'h0;
  endfunction

  function automatic bit ro_of(input int d);
    return d == 2;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      ld_en[d]   = 1'b0;
    end
  endtask

  // Full transfer; returns with the completion edge still ahead,
  // so a following call issues its setup right after pready.
  task automatic xfer(input int d, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int ldn,
                      input logic [IW-1:0] la,
                      input logic [31:0] lv, input string tag);
    int cyc;
    bit ok;
    logic [31:0] got_d;
    logic got_e;
    bit bad;
    longint a64;
    int idx;
    int exp_cyc;
    logic [31:0] exp_d;

    @(posedge clk); #1;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    pstrb[d]   = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    cyc = 0;
    ok  = 1'b0;
    got_d = '0;
    got_e = 1'b0;
    while (!ok && cyc < 40) begin
      ld_en[d]   = (cyc < ldn);
      ld_addr[d] = la;
      ld_data[d] = lv;
      @(negedge clk);
      cyc++;
      if (rdy[d]) begin
        ok = 1'b1;
        got_d = rdata[d];
        got_e = serr[d];
      end else begin
        @(posedge clk); #1;
      end
    end
    ld_en[d] = 1'b0;

    if (ldn > 0) mm[d][la] = lv;
    a64 = longint'(a);
    bad = (a[1:0] != 2'b00) || (a64 < base_of(d)) ||
          (a64 >= base_of(d) + 4 * DEP) || (wr && ro_of(d));
    idx = int'(((a64 - base_of(d)) >> 2) % DEP);
    exp_cyc = (ldn > wait_of(d)) ? ldn + 1 : wait_of(d) + 1;
    exp_d = bad ? 32'h0 : mm[d][idx];

    chk({tag, ".done"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, ".lat"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, ".err"}, 32'(got_e), 32'(bad));
      if (!wr || bad) chk({tag, ".data"}, got_d, exp_d);
      if (wr && !bad) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) mm[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      ld_en[d] = 0; ld_addr[d] = '0; ld_data[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("rst.pready",  32'(rdy[d]),  32'd0);
      chk("rst.pslverr", 32'(serr[d]), 32'd0);
      chk("rst.prdata",  rdata[d],     32'd0);
      chk("rst.busy",    32'(busy[d]), 32'd0);
    end
    rst_n = 1'b1;

    for (int w = 0; w < DEP; w++) begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        v = (d == 1) ? 32'h0 : $urandom;
        if (d == 0 && w == 3) v = 32'hDEADBEEF;
        ld_en[d]   = 1'b1;
        ld_addr[d] = IW'(w);
        ld_data[d] = v;
        mm[d][w]   = v;
      end
    end
    idle_all();

    xfer(0, 0, 32'h0C, 0, 4'h0, 0, 0, 0, "rd_beef");
    xfer(1, 1, 32'h10, 32'h11223344, 4'b0101, 0, 0, 0, "wr_strb");
    xfer(1, 0, 32'h10, 0, 4'hF, 0, 0, 0, "rd_strb");
    xfer(0, 0, 32'h06, 0, 4'h0, 0, 0, 0, "rd_mis");
    xfer(0, 0, 32'h100, 0, 4'h0, 0, 0, 0, "rd_top");
    xfer(0, 0, 32'hFC, 0, 4'h0, 0, 0, 0, "rd_last");
    xfer(2, 1, 32'h0, 32'h12345678, 4'hF, 0, 0, 0, "ro_wr");
    xfer(2, 0, 32'h0, 0, 4'h0, 0, 0, 0, "ro_rd");
    xfer(3, 0, 32'h1FC, 0, 4'h0, 0, 0, 0, "rd_below");
    xfer(3, 0, 32'h200, 0, 4'h0, 0, 0, 0, "rd_base");
    xfer(3, 0, 32'h300, 0, 4'h0, 0, 0, 0, "rd_above");
    xfer(1, 1, 32'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 0, "wr_nostrb");
    xfer(1, 0, 32'h14, 0, 4'h0, 0, 0, 0, "rd_nostrb");
    xfer(0, 0, 32'h14, 0, 4'h0, 2, 6'd5, 32'hA5A5A5A5, "ld_defer");

    idle_all();
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 32'h0C;
    @(negedge clk);
    chk("noset.pready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("noset.busy", 32'(busy[0]), 32'd0);
    idle_all();

    @(posedge clk); #1;
    psel[3] = 1; penable[3] = 0; pwrite[3] = 1;
    paddr[3] = 32'h220; pwdata[3] = 32'hCAFEF00D; pstrb[3] = 4'hF;
    @(posedge clk); #1;
    penable[3] = 1'b1;
    @(negedge clk);
    chk("abort.rdy1", 32'(rdy[3]), 32'd0);
    @(posedge clk); #1;
    psel[3] = 1'b0; penable[3] = 1'b0;
    @(negedge clk);
    chk("abort.rdy2", 32'(rdy[3]), 32'd0);
    @(negedge clk);
    chk("abort.busy", 32'(busy[3]), 32'd0);
    xfer(3, 0, 32'h220, 0, 4'h0, 0, 0, 0, "abort.rd");
    idle_all();

    @(posedge clk); #1;
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 32'h30; pwdata[1] = 32'h55AA55AA; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk);
    chk("rstw.busy1", 32'(busy[1]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstw.pready", 32'(rdy[1]), 32'd0);
    chk("rstw.busy", 32'(busy[1]), 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 0, 32'h30, 0, 4'h0, 0, 0, 0, "rstw.rd");

    for (int i = 0; i < 200; i++) begin
      int d, r, w, ldn;
      longint b;
      logic [31:0] a;
      bit wr;
      d = $urandom_range(0, ND - 1);
      b = base_of(d);
      w = $urandom_range(0, DEP - 1);
      r = $urandom_range(0, 9);
      if (r == 0)
        a = 32'(b + 4 * w + $urandom_range(1, 3));
      else if (r == 1)
        a = 32'(b + 4 * DEP + 4 * $urandom_range(0, 3));
      else if (r == 2 && b != 0)
        a = 32'(b - 4 * $urandom_range(1, 4));
      else
        a = 32'(b + 4 * w);
      wr = $urandom_range(0, 1) == 1;
      ldn = $urandom_range(0, 3);
      if (ldn == 1 && wait_of(d) <= 1) ldn = 0;
      xfer(d, wr, a, $urandom, 4'($urandom), ldn,
           IW'($urandom), $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) idle_all();
    end
    idle_all();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
